dica_ckpt_engine: RTL
=====================

# dica_ckpt_engine

Checkpoint copy engine, consumer side of the DiCA dirty-block tracker. On a checkpoint request it snapshots the tracker's dirty-block bitmap and copies every dirty DMEM block, word by word, into a shadow region in non-volatile memory. It pulses a per-block clear back to the tracker, then writes an epoch commit word. The engine sits between the tracker, the openMSP430 DMEM read port and the NVM write port. It holds the CPU (`cpu_halt`) for the whole copy.

## Interface
- `DMEM_BASE`, default `` `DMEM_BASE ``: byte base address of DMEM.
- `DMEM_SIZE`, default `` `DMEM_SIZE ``: DMEM size in bytes.
- `BLK_SIZE`, default 128: block size in bytes. Must be even.
- `TOTAL_BLOCKS`, default `DMEM_SIZE/BLK_SIZE`: bitmap width.
- `NVM_BASE`, default 16'h8000: byte base address of the NVM shadow region. The shadow region mirrors the DMEM layout.
- `NVM_COMMIT_ADDR`, default 16'hFFC0: byte address of the epoch commit word.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: checkpoint request, level or pulse. Driven by the tracker's `irq_chkpnt`.
- `dirty`, in, TOTAL_BLOCKS: dirty-block bitmap (`D_Table`).
- `dmem_cen`, out, 1: DMEM read enable, active-low.
- `dmem_addr`, out, 16: DMEM byte address.
- `dmem_dout`, in, 16: DMEM read data. Valid one cycle after `dmem_cen`=0.
- `nvm_wen`, out, 1: NVM write request, active-high.
- `nvm_addr`, out, 16: NVM byte address.
- `nvm_din`, out, 16: NVM write data.
- `nvm_ready`, in, 1: NVM accepts a write in any cycle where `nvm_wen` and `nvm_ready` are both high.
- `blk_clr`, out, TOTAL_BLOCKS: one-hot, one-cycle pulse that clears the copied block in the tracker.
- `cpu_halt`, out, 1: high whenever the FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse when a checkpoint is committed.
- `epoch`, out, 16: count of committed checkpoints.

## Operation
- States: IDLE, SCAN, RD, WR, COMMIT, DONE. The state register and all datapath registers are updated on the clk edge.
- IDLE:
  - When `start`=1, latch `snap<=dirty`, set `blk<=0`, `word<=0`, go to SCAN.
  - When `start`=0, stay in IDLE.
- SCAN tests one block per cycle:
  - If `snap[blk]`=1, set `word<=0` and go to RD.
  - Else if `blk`==TOTAL_BLOCKS-1, go to COMMIT.
  - Else increment `blk` and stay in SCAN.
- RD:
  - Drive `dmem_cen`=0 and `dmem_addr = DMEM_BASE + blk*BLK_SIZE + 2*word`.
  - Go to WR unconditionally.
- WR:
  - On WR entry, capture `dmem_dout` into `wdata`. `nvm_din` drives `wdata`.
  - Drive `nvm_wen`=1 and `nvm_addr = NVM_BASE + blk*BLK_SIZE + 2*word`. Hold address and data stable until `nvm_ready`.
  - On acceptance with `word`<BLK_SIZE/2-1: increment `word`, go to RD.
  - On acceptance of the last word: `blk_clr[blk]`=1 in this cycle. If `blk`==TOTAL_BLOCKS-1 go to COMMIT, else increment `blk` and go to SCAN.
- COMMIT:
  - Drive `nvm_wen`=1, `nvm_addr=NVM_COMMIT_ADDR`, `nvm_din=epoch+1`.
  - On acceptance, `epoch<=epoch+1` and go to DONE.
  - `epoch` wraps from 16'hFFFF to 16'h0000.
- DONE: `done`=1 for one cycle, then go to IDLE. A `start` sampled in DONE is ignored.
- `start` is ignored in every non-IDLE state. If `start` is still high on return to IDLE, a new checkpoint begins.
- Bits set in `dirty` after the snapshot are not copied in this checkpoint and are not cleared.
- An empty snapshot still scans all blocks and still commits.
- Arithmetic:
  - `blk` is `$clog2(TOTAL_BLOCKS)` bits wide.
  - `word` is `$clog2(BLK_SIZE/2)` bits wide.
  - Address sums are computed in 16 bits. Overflow past 16'hFFFF is a parameter error and is not checked in RTL.

## Timing
- Reset values:
  - State is IDLE.
  - `dmem_cen`=1, `nvm_wen`=0, `blk_clr`=0, `cpu_halt`=0, `done`=0.
  - `epoch`=0, `snap`=0, `dmem_addr`=0, `nvm_addr`=0, `nvm_din`=0.
- Reset asserted mid-copy or mid-commit aborts in the same edge. No `blk_clr` and no `done` are emitted. A partially written block is recopied at the next checkpoint.
- Throughput with `nvm_ready` tied high is 2 cycles per word, i.e. BLK_SIZE cycles per dirty block. Each block scan costs 1 cycle.
- Latency with `start` sampled at edge 0 and `nvm_ready`=1: `done` is high in cycle `1 + TOTAL_BLOCKS + BLK_SIZE*D + 1`, where D is the number of dirty blocks.
- Each cycle `nvm_ready` is low adds exactly one cycle to that latency.
- `cpu_halt` rises the cycle after `start` is sampled and falls the cycle after DONE.

## Structure
- Shared include `dica_defines.v` holds:
  - the state encodings,
  - the BLK_SIZE/TOTAL_BLOCKS derivation, shared with the tracker so both agree on the bitmap width,
  - the NVM_BASE and NVM_COMMIT_ADDR defaults.
- Single module; no sub-module is natural. Address generation is inline shift and add; the scan is linear.

## Test plan
TOTAL_BLOCKS=16, BLK_SIZE=128, `nvm_ready`=1 unless stated.
1. Empty bitmap: `dirty`=0, `start` pulse at cycle 0 -> 16 SCAN cycles, commit writes 16'h0001 to NVM_COMMIT_ADDR, `done` in cycle 18, `epoch`=1, `blk_clr` never asserted.
2. Single dirty block: `dirty`=16'h0001, DMEM preloaded with word pattern `addr^16'hA5A5` -> 64 NVM writes to NVM_BASE..NVM_BASE+126 carrying that pattern, `blk_clr`=16'h0001 in cycle 129, `done` in cycle 146.
3. NVM backpressure: `dirty`=16'h8000, `nvm_ready` low for 3 cycles on word 5 -> `nvm_addr`/`nvm_din` stable during the stall, `done` 3 cycles later than the no-stall run, data intact.
4. Snapshot isolation: `dirty`=16'h0002 at start; set bit 3 mid-copy -> only block 1 copied and cleared, bit 3 untouched.
5. Reset mid-copy: assert `reset_n`=0 on word 20 of block 0 -> next edge shows IDLE, `nvm_wen`=0, `cpu_halt`=0, `epoch`=0, no `done`/`blk_clr`. A following checkpoint copies all 64 words.
6. Epoch wrap and held start: preload `epoch`=16'hFFFF (via 65535 empty checkpoints, or force in the bench), hold `start` high -> commit word 16'h0000, `epoch`=0, then a second checkpoint starts immediately after DONE.

Source files
------------

// File: rtl/dica_ckpt_engine_pkg.sv
// Shared types and default geometry for the DiCA checkpoint engine.
// The tracker uses the same defaults, so both sides agree on the bitmap width.
package dica_ckpt_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RD,
        ST_WR,
        ST_COMMIT,
        ST_DONE
    } state_t;

    localparam logic [15:0] DEF_DMEM_BASE       = 16'h0200;
    localparam int          DEF_DMEM_SIZE       = 2048;
    localparam int          DEF_BLK_SIZE        = 128;
    localparam int          DEF_TOTAL_BLOCKS    = DEF_DMEM_SIZE / DEF_BLK_SIZE;
    localparam logic [15:0] DEF_NVM_BASE        = 16'h8000;
    localparam logic [15:0] DEF_NVM_COMMIT_ADDR = 16'hFFC0;

endpackage

// File: rtl/dica_ckpt_engine_if.sv
// Bundle of tracker, DMEM read port, NVM write port and CPU control signals.
// master = checkpoint engine, slave = surrounding system.
interface dica_ckpt_engine_if
    import dica_ckpt_engine_pkg::*;
#(
    parameter int TOTAL_BLOCKS = DEF_TOTAL_BLOCKS
);
    logic                    start;
    logic [TOTAL_BLOCKS-1:0] dirty;
    logic                    dmem_cen;
    logic [15:0]             dmem_addr;
    logic [15:0]             dmem_dout;
    logic                    nvm_wen;
    logic [15:0]             nvm_addr;
    logic [15:0]             nvm_din;
    logic                    nvm_ready;
    logic [TOTAL_BLOCKS-1:0] blk_clr;
    logic                    cpu_halt;
    logic                    done;
    logic [15:0]             epoch;

    modport master (
        input  start, dirty, dmem_dout, nvm_ready,
        output dmem_cen, dmem_addr, nvm_wen, nvm_addr, nvm_din,
               blk_clr, cpu_halt, done, epoch
    );

    modport slave (
        output start, dirty, dmem_dout, nvm_ready,
        input  dmem_cen, dmem_addr, nvm_wen, nvm_addr, nvm_din,
               blk_clr, cpu_halt, done, epoch
    );
endinterface

// File: rtl/dica_ckpt_engine.sv
// Checkpoint copy engine: snapshots the dirty bitmap, copies each dirty DMEM
// block word by word into the NVM shadow region, then writes the epoch commit word.
module dica_ckpt_engine
    import dica_ckpt_engine_pkg::*;
#(
    parameter logic [15:0] DMEM_BASE       = DEF_DMEM_BASE,
    parameter int          DMEM_SIZE       = DEF_DMEM_SIZE,
    parameter int          BLK_SIZE        = DEF_BLK_SIZE,
    parameter int          TOTAL_BLOCKS    = DMEM_SIZE / BLK_SIZE,
    parameter logic [15:0] NVM_BASE        = DEF_NVM_BASE,
    parameter logic [15:0] NVM_COMMIT_ADDR = DEF_NVM_COMMIT_ADDR
) (
    input  logic clk,
    input  logic reset_n,
    dica_ckpt_engine_if.master bus
);
    localparam int WORDS  = BLK_SIZE / 2;
    localparam int BLK_W  = (TOTAL_BLOCKS > 1) ? $clog2(TOTAL_BLOCKS) : 1;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t                  r_state;
    state_t                  w_next;
    logic [TOTAL_BLOCKS-1:0] r_snap;
    logic [BLK_W-1:0]        r_blk;
    logic [WORD_W-1:0]       r_word;
    logic [15:0]             r_wdata;
    logic                    r_wr_first;
    logic [15:0]             r_epoch;

    logic [15:0] w_offset;
    logic        w_last_blk;
    logic        w_last_word;
    logic        w_dmem_cen;
    logic [15:0] w_dmem_addr;
    logic        w_nvm_wen;
    logic [15:0] w_nvm_addr;
    logic [15:0] w_nvm_din;
    logic        w_clr_hit;

    assign w_offset    = 16'(r_blk) * 16'(BLK_SIZE) + 16'({r_word, 1'b0});
    assign w_last_blk  = (r_blk == BLK_W'(TOTAL_BLOCKS - 1));
    assign w_last_word = (r_word == WORD_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // The DMEM word is only valid in the first WR cycle; it is bypassed to the
    // NVM then and held in r_wdata in case the write stalls.
    always_comb begin
        w_next      = r_state;
        w_dmem_cen  = 1'b1;
        w_dmem_addr = 16'h0000;
        w_nvm_wen   = 1'b0;
        w_nvm_addr  = 16'h0000;
        w_nvm_din   = 16'h0000;
        w_clr_hit   = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_SCAN;
            ST_SCAN: begin
                if (r_snap[r_blk])   w_next = ST_RD;
                else if (w_last_blk) w_next = ST_COMMIT;
            end
            ST_RD: begin
                w_dmem_cen  = 1'b0;
                w_dmem_addr = DMEM_BASE + w_offset;
                w_next      = ST_WR;
            end
            ST_WR: begin
                w_nvm_wen  = 1'b1;
                w_nvm_addr = NVM_BASE + w_offset;
                w_nvm_din  = r_wr_first ? bus.dmem_dout : r_wdata;
                if (bus.nvm_ready) begin
                    if (w_last_word) begin
                        w_clr_hit = 1'b1;
                        w_next    = w_last_blk ? ST_COMMIT : ST_SCAN;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_COMMIT: begin
                w_nvm_wen  = 1'b1;
                w_nvm_addr = NVM_COMMIT_ADDR;
                w_nvm_din  = r_epoch + 16'd1;
                if (bus.nvm_ready) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_snap     <= '0;
            r_blk      <= '0;
            r_word     <= '0;
            r_wdata    <= 16'h0000;
            r_wr_first <= 1'b0;
            r_epoch    <= 16'h0000;
        end else begin
            r_wr_first <= (r_state == ST_RD);
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_snap <= bus.dirty;
                        r_blk  <= '0;
                        r_word <= '0;
                    end
                end
                ST_SCAN: begin
                    if (r_snap[r_blk])    r_word <= '0;
                    else if (!w_last_blk) r_blk  <= r_blk + BLK_W'(1);
                end
                ST_WR: begin
                    if (r_wr_first) r_wdata <= bus.dmem_dout;
                    if (bus.nvm_ready) begin
                        if (!w_last_word)     r_word <= r_word + WORD_W'(1);
                        else if (!w_last_blk) r_blk  <= r_blk + BLK_W'(1);
                    end
                end
                ST_COMMIT: begin
                    if (bus.nvm_ready) r_epoch <= r_epoch + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Pulses are masked while reset is asserted so an aborted copy never
    // reports a clear or a commit on the aborting edge.
    assign bus.dmem_cen  = w_dmem_cen;
    assign bus.dmem_addr = w_dmem_addr;
    assign bus.nvm_wen   = w_nvm_wen;
    assign bus.nvm_addr  = w_nvm_addr;
    assign bus.nvm_din   = w_nvm_din;
    assign bus.blk_clr   = (w_clr_hit && reset_n) ? (TOTAL_BLOCKS'(1) << r_blk) : '0;
    assign bus.cpu_halt  = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE) && reset_n;
    assign bus.epoch     = r_epoch;

endmodule
